// File: rtl/control_unit.sv
// control_unit: microcode sequencer for the 8-bit SAP-1.5 computer.
// Walks fetch/decode/execute per instruction and decodes the datapath control
// word from the current state and the latched opcode. Exactly one bus source
// (or none) is enabled in any cycle; HLT (and optionally illegal opcodes) park
// the machine in S_HALT until reset.
module control_unit #(
    parameter int OPCODE_W       = 4,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_zero,
    input  logic                flag_carry,
    output logic                pc_enable,
    output logic                load_pc,
    output logic                oe_pc,
    output logic                load_mar,
    output logic                oe_ram,
    output logic                load_ram,
    output logic                load_ir,
    output logic                oe_ir,
    output logic                load_a,
    output logic                oe_a,
    output logic                load_b,
    output logic                oe_alu,
    output logic                alu_sub,
    output logic                load_flags,
    output logic                load_o,
    output logic                halt,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_RESET       = 3'd0,
        S_FETCH_PC    = 3'd1,
        S_FETCH_INSTR = 3'd2,
        S_DECODE      = 3'd3,
        S_EXEC1       = 3'd4,
        S_EXEC2       = 3'd5,
        S_EXEC3       = 3'd6,
        S_HALT        = 3'd7
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h9);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    state_t              state;
    logic [OPCODE_W-1:0] opcode_q;

    // Opcodes that have at least one execute step.
    function automatic logic has_exec(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA,
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: has_exec = 1'b1;
            default:                             has_exec = 1'b0;
        endcase
    endfunction

    // Anything not in the instruction set counts as illegal.
    function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
        is_illegal = !has_exec(op) && (op != OP_NOP) && (op != OP_HLT);
    endfunction

    function automatic logic goes_to_halt(input logic [OPCODE_W-1:0] op);
        goes_to_halt = (op == OP_HLT) || (is_illegal(op) && !NOP_ON_ILLEGAL);
    endfunction

    // Memory-operand instructions need a second execute step.
    function automatic logic has_exec2(input logic [OPCODE_W-1:0] op);
        has_exec2 = (op == OP_LDA) || (op == OP_LDB) || (op == OP_ADD) ||
                    (op == OP_SUB) || (op == OP_STA);
    endfunction

    function automatic logic has_exec3(input logic [OPCODE_W-1:0] op);
        has_exec3 = (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Sequencer state and opcode latch; the opcode is only sampled in S_DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RESET;
            opcode_q <= '0;
        end else begin
            case (state)
                S_RESET:       state <= S_FETCH_PC;
                S_FETCH_PC:    state <= S_FETCH_INSTR;
                S_FETCH_INSTR: state <= S_DECODE;
                S_DECODE: begin
                    opcode_q <= opcode;
                    if (goes_to_halt(opcode))
                        state <= S_HALT;
                    else if (has_exec(opcode))
                        state <= S_EXEC1;
                    else
                        state <= S_FETCH_PC;
                end
                S_EXEC1:       state <= has_exec2(opcode_q) ? S_EXEC2 : S_FETCH_PC;
                S_EXEC2:       state <= has_exec3(opcode_q) ? S_EXEC3 : S_FETCH_PC;
                S_EXEC3:       state <= S_FETCH_PC;
                S_HALT:        state <= S_HALT;
                default:       state <= S_RESET;
            endcase
        end
    end

    // Control word decode from state and latched opcode; conditional jumps
    // gate load_pc with the live flag.
    always_comb begin
        pc_enable  = 1'b0;
        load_pc    = 1'b0;
        oe_pc      = 1'b0;
        load_mar   = 1'b0;
        oe_ram     = 1'b0;
        load_ram   = 1'b0;
        load_ir    = 1'b0;
        oe_ir      = 1'b0;
        load_a     = 1'b0;
        oe_a       = 1'b0;
        load_b     = 1'b0;
        oe_alu     = 1'b0;
        alu_sub    = 1'b0;
        load_flags = 1'b0;
        load_o     = 1'b0;
        halt       = 1'b0;
        case (state)
            S_FETCH_PC: begin
                oe_pc    = 1'b1;
                load_mar = 1'b1;
            end
            S_FETCH_INSTR: begin
                oe_ram    = 1'b1;
                load_ir   = 1'b1;
                pc_enable = 1'b1;
            end
            S_EXEC1: begin
                case (opcode_q)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
                        oe_ir    = 1'b1;
                        load_mar = 1'b1;
                    end
                    OP_LDI: begin
                        oe_ir  = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_JMP: begin
                        oe_ir   = 1'b1;
                        load_pc = 1'b1;
                    end
                    OP_JC: begin
                        oe_ir   = 1'b1;
                        load_pc = flag_carry;
                    end
                    OP_JZ: begin
                        oe_ir   = 1'b1;
                        load_pc = flag_zero;
                    end
                    OP_OUT: begin
                        oe_a   = 1'b1;
                        load_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                case (opcode_q)
                    OP_LDA: begin
                        oe_ram = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_LDB, OP_ADD, OP_SUB: begin
                        oe_ram = 1'b1;
                        load_b = 1'b1;
                    end
                    OP_STA: begin
                        oe_a     = 1'b1;
                        load_ram = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC3: begin
                if (has_exec3(opcode_q)) begin
                    oe_alu     = 1'b1;
                    load_a     = 1'b1;
                    load_flags = 1'b1;
                    alu_sub    = (opcode_q == OP_SUB);
                end
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small SAP-1.5 datapath (RAM, PC, MAR, IR, A, B,
// ALU, flags, output register) is steered by the sequencer's strobes, so whole
// programs run end to end. A second instance with NOP_ON_ILLEGAL=0 is driven
// directly for the halt-on-illegal case.
module tb_control_unit;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset0 = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic [3:0] opcode;
    logic       flag_zero, flag_carry;
    logic       pc_enable, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir, oe_ir;
    logic       load_a, oe_a, load_b, oe_alu, alu_sub, load_flags, load_o, halt;
    logic [2:0] state_o;
    logic [15:0] cw;

    // Halt-on-illegal instance signals
    logic [3:0] opcode0 = 4'h6;
    logic       z_fz = 1'b0, z_fc = 1'b0;
    logic       z_pc_enable, z_load_pc, z_oe_pc, z_load_mar, z_oe_ram, z_load_ram, z_load_ir, z_oe_ir;
    logic       z_load_a, z_oe_a, z_load_b, z_oe_alu, z_alu_sub, z_load_flags, z_load_o, z_halt;
    logic [2:0] z_state;
    logic [15:0] z_cw;

    control_unit #(.OPCODE_W(4), .NOP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .pc_enable(pc_enable), .load_pc(load_pc), .oe_pc(oe_pc), .load_mar(load_mar),
        .oe_ram(oe_ram), .load_ram(load_ram), .load_ir(load_ir), .oe_ir(oe_ir),
        .load_a(load_a), .oe_a(oe_a), .load_b(load_b), .oe_alu(oe_alu),
        .alu_sub(alu_sub), .load_flags(load_flags), .load_o(load_o), .halt(halt),
        .state_o(state_o)
    );

    control_unit #(.OPCODE_W(4), .NOP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .opcode(opcode0),
        .flag_zero(z_fz), .flag_carry(z_fc),
        .pc_enable(z_pc_enable), .load_pc(z_load_pc), .oe_pc(z_oe_pc), .load_mar(z_load_mar),
        .oe_ram(z_oe_ram), .load_ram(z_load_ram), .load_ir(z_load_ir), .oe_ir(z_oe_ir),
        .load_a(z_load_a), .oe_a(z_oe_a), .load_b(z_load_b), .oe_alu(z_oe_alu),
        .alu_sub(z_alu_sub), .load_flags(z_load_flags), .load_o(z_load_o), .halt(z_halt),
        .state_o(z_state)
    );

    assign cw = {pc_enable, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir, oe_ir,
                 load_a, oe_a, load_b, oe_alu, alu_sub, load_flags, load_o, halt};
    assign z_cw = {z_pc_enable, z_load_pc, z_oe_pc, z_load_mar, z_oe_ram, z_load_ram,
                   z_load_ir, z_oe_ir, z_load_a, z_oe_a, z_load_b, z_oe_alu, z_alu_sub,
                   z_load_flags, z_load_o, z_halt};

    // Datapath model
    logic [7:0] prog [16];
    logic [7:0] ram  [16];
    logic [3:0] pc, mar;
    logic [7:0] ir, a, b, outr, bus;
    logic       fz, fc;
    logic [8:0] alu_sum;

    assign alu_sum    = {1'b0, a} + (alu_sub ? ({1'b0, ~b} + 9'd1) : {1'b0, b});
    assign opcode     = ir[7:4];
    assign flag_zero  = fz;
    assign flag_carry = fc;

    always_comb begin
        bus = 8'h00;
        if (oe_pc)       bus = {4'h0, pc};
        else if (oe_ram) bus = ram[mar];
        else if (oe_ir)  bus = {4'h0, ir[3:0]};
        else if (oe_a)   bus = a;
        else if (oe_alu) bus = alu_sum[7:0];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram <= prog; pc <= 4'h0; mar <= 4'h0; ir <= 8'h00;
            a <= 8'h00; b <= 8'h00; outr <= 8'h00; fz <= 1'b0; fc <= 1'b0;
        end else begin
            if (load_mar) mar <= bus[3:0];
            if (load_ram) ram[mar] <= bus;
            if (load_ir)  ir <= bus;
            if (load_a)   a <= bus;
            if (load_b)   b <= bus;
            if (load_o)   outr <= bus;
            if (load_flags) begin
                fc <= alu_sum[8];
                fz <= (alu_sum[7:0] == 8'h00);
            end
            if (load_pc)        pc <= bus[3:0];
            else if (pc_enable) pc <= pc + 4'h1;
        end
    end

    // Per-cycle observation counters, sampled on the falling edge
    int n_bus_viol = 0, n_dec_strobe = 0, n_halt_strobe = 0, n_pc_noir = 0;
    int n_load_flags = 0, n_alu_sub = 0, n_load_pc = 0, n_load_ram = 0;

    always @(negedge clk) begin
        if ($countones({oe_pc, oe_ram, oe_ir, oe_a, oe_alu}) > 1 ||
            $countones({z_oe_pc, z_oe_ram, z_oe_ir, z_oe_a, z_oe_alu}) > 1)
            n_bus_viol <= n_bus_viol + 1;
        if (state_o == 3'd3 && cw != 16'h0000) n_dec_strobe <= n_dec_strobe + 1;
        if ((halt && cw != 16'h0001) || (z_halt && z_cw != 16'h0001))
            n_halt_strobe <= n_halt_strobe + 1;
        if (load_pc && !oe_ir) n_pc_noir <= n_pc_noir + 1;
        if (load_flags) n_load_flags <= n_load_flags + 1;
        if (alu_sub)    n_alu_sub <= n_alu_sub + 1;
        if (load_pc)    n_load_pc <= n_load_pc + 1;
        if (load_ram)   n_load_ram <= n_load_ram + 1;
    end

    // Scoreboard
    string sb_tag [$];
    int    sb_exp [$];
    int    tests = 0;
    int    fails = 0;
    int    cyc;
    int    b_lf, b_sub, b_lpc, b_lram, b_viol;

    function automatic int viol_now();
        return n_bus_viol + n_dec_strobe + n_halt_strobe + n_pc_noir;
    endfunction

    task automatic expect_val(input string tag, input int v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic check(input string tag, input int obs);
        string etag;
        int    exp;
        etag = "<empty>";
        exp  = -1;
        if (sb_exp.size() > 0) begin
            etag = sb_tag.pop_front();
            exp  = sb_exp.pop_front();
        end
        tests++;
        assert (obs === exp && etag == tag)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (queued %s)", tag, obs, exp, etag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic snap();
        b_lf   = n_load_flags;
        b_sub  = n_alu_sub;
        b_lpc  = n_load_pc;
        b_lram = n_load_ram;
        b_viol = viol_now();
    endtask

    // Hold reset for two edges, then release just after a rising edge.
    task automatic start_run();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        snap();
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_to_halt();
        while (!halt && cyc < 200) tick();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        // LDB then HLT
        clear_prog();
        prog[0] = 8'h2F; prog[1] = 8'hF0; prog[15] = 8'h11;
        expect_val("rst_cw", 0);
        expect_val("rst_state", 0);
        expect_val("ldb_b_before", 0);
        expect_val("ldb_b_after5", 8'h11);
        expect_val("ldb_halt_cycles", 9);
        expect_val("ldb_halt_state", 7);
        expect_val("ldb_halt_cw", 1);
        expect_val("ldb_viol", 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cw", int'(cw));
        check("rst_state", int'(state_o));
        start_run();
        repeat (5) tick();
        check("ldb_b_before", int'(b));
        tick();
        check("ldb_b_after5", int'(b));
        run_to_halt();
        check("ldb_halt_cycles", cyc);
        check("ldb_halt_state", int'(state_o));
        check("ldb_halt_cw", int'(cw));
        check("ldb_viol", viol_now() - b_viol);

        // LDA 0xE, ADD 0xF, OUT, HLT: 0x05 + 0xFC
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'hFC;
        expect_val("add_cycles", 19);
        expect_val("add_a", 8'h01);
        expect_val("add_out", 8'h01);
        expect_val("add_carry", 1);
        expect_val("add_zero", 0);
        expect_val("add_load_flags", 1);
        expect_val("add_alu_sub", 0);
        expect_val("add_viol", 0);
        start_run();
        run_to_halt();
        check("add_cycles", cyc);
        check("add_a", int'(a));
        check("add_out", int'(outr));
        check("add_carry", int'(fc));
        check("add_zero", int'(fz));
        check("add_load_flags", n_load_flags - b_lf);
        check("add_alu_sub", n_alu_sub - b_sub);
        check("add_viol", viol_now() - b_viol);

        // LDA 5, SUB 5 (Z=1), JZ 5 taken -> LDI 7, OUT, HLT
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h4E; prog[2] = 8'h95; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[5] = 8'h67; prog[6] = 8'hE0; prog[7] = 8'hF0; prog[14] = 8'h05;
        expect_val("jz_cycles", 27);
        expect_val("jz_zero", 1);
        expect_val("jz_out", 7);
        expect_val("jz_load_pc", 1);
        expect_val("jz_alu_sub", 1);
        expect_val("jz_viol", 0);
        start_run();
        run_to_halt();
        check("jz_cycles", cyc);
        check("jz_zero", int'(fz));
        check("jz_out", int'(outr));
        check("jz_load_pc", n_load_pc - b_lpc);
        check("jz_alu_sub", n_alu_sub - b_sub);
        check("jz_viol", viol_now() - b_viol);

        // LDI 3, JC 5 and JZ 5 both not taken (flags clear), OUT, HLT
        clear_prog();
        prog[0] = 8'h63; prog[1] = 8'h85; prog[2] = 8'h95; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[5] = 8'h67; prog[6] = 8'hE0; prog[7] = 8'hF0;
        expect_val("jn_cycles", 20);
        expect_val("jn_out", 3);
        expect_val("jn_load_pc", 0);
        start_run();
        run_to_halt();
        check("jn_cycles", cyc);
        check("jn_out", int'(outr));
        check("jn_load_pc", n_load_pc - b_lpc);

        // Illegal 0xB passes as a 3-cycle NOP, then LDI 9, OUT, HLT
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'h69; prog[2] = 8'hE0; prog[3] = 8'hF0;
        expect_val("ill_cycles", 15);
        expect_val("ill_out", 9);
        expect_val("ill_viol", 0);
        start_run();
        run_to_halt();
        check("ill_cycles", cyc);
        check("ill_out", int'(outr));
        check("ill_viol", viol_now() - b_viol);

        // Illegal 0xB halts when NOP_ON_ILLEGAL=0; later opcodes ignored
        expect_val("ill0_decode_seen", 3);
        expect_val("ill0_halt", 1);
        expect_val("ill0_state", 7);
        expect_val("ill0_cw", 1);
        expect_val("ill0_stay_halt", 1);
        expect_val("ill0_stay_state", 7);
        opcode0 = 4'h6;
        @(posedge clk);
        #1;
        reset0 = 1'b1;
        cyc = 0;
        while (z_state != 3'd3 && cyc < 10) tick();
        check("ill0_decode_seen", int'(z_state));
        opcode0 = 4'hB;
        tick();
        check("ill0_halt", int'(z_halt));
        check("ill0_state", int'(z_state));
        check("ill0_cw", int'(z_cw));
        opcode0 = 4'h6;
        repeat (3) tick();
        check("ill0_stay_halt", int'(z_halt));
        check("ill0_stay_state", int'(z_state));

        // Reset pulse during S_EXEC2 of STA: no RAM write, state 0 at once
        clear_prog();
        prog[0] = 8'h6A; prog[1] = 8'h5F; prog[2] = 8'hF0;
        expect_val("sta_in_exec2", 5);
        expect_val("sta_rst_state", 0);
        expect_val("sta_rst_cw", 0);
        expect_val("sta_load_ram", 0);
        expect_val("sta_hold_state", 0);
        start_run();
        while (state_o != 3'd5 && cyc < 30) tick();
        check("sta_in_exec2", int'(state_o));
        reset = 1'b0;
        #1;
        check("sta_rst_state", int'(state_o));
        check("sta_rst_cw", int'(cw));
        repeat (3) tick();
        check("sta_load_ram", n_load_ram - b_lram);
        check("sta_hold_state", int'(state_o));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
